rle_block_assembler: RTL and testbench

RLE_BLOCK_ASSEMBLER -- requirements
Module: rle_block_assembler

---
 rtl/jpeg_pkg.sv | 19 +
 rtl/rle_block_assembler.sv | 148 ++++++++++++++
 tb/tb_rle_block_assembler.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder constants and types: coefficient/run widths, block size,
// and the block assembler state encoding.
package jpeg_pkg;

    localparam int COEF_W    = 8;
    localparam int RUN_W     = 6;
    localparam int BLK_COEFS = 64;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Bit offset of coefficient idx inside a packed block (index 0 sits in the top bits).
    function automatic int blk_offset(input int idx, input int coef_w);
        return (BLK_COEFS - 1 - idx) * coef_w;
    endfunction

endpackage

// File: rtl/rle_block_assembler.sv
// Expands (run, level, eob) tokens into a 64-coefficient zigzag-ordered block
// and hands complete blocks downstream through a one-deep output register.
module rle_block_assembler
    import jpeg_pkg::BLK_COEFS, jpeg_pkg::state_t, jpeg_pkg::FILL, jpeg_pkg::WAIT,
           jpeg_pkg::blk_offset;
#(
    parameter int COEF_W = jpeg_pkg::COEF_W,
    parameter int RUN_W  = jpeg_pkg::RUN_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [RUN_W-1:0]          in_run,
    input  logic [COEF_W-1:0]         in_level,
    input  logic                      in_eob,
    output logic [BLK_COEFS*COEF_W-1:0] blk_data,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic                      err_overflow
);

    // Handshakes: a token moves when in_valid && in_ready on a rising edge;
    // a block moves when blk_valid && blk_ready on a rising edge.

    localparam int POS_W = $clog2(BLK_COEFS) + 1;
    localparam int IDX_W = $clog2(BLK_COEFS);
    localparam int SUM_W = ((RUN_W > POS_W) ? RUN_W : POS_W) + 1;
    localparam logic [SUM_W-1:0] LAST_IDX = SUM_W'(BLK_COEFS - 1);

    state_t                         state;
    state_t                         state_next;
    logic [POS_W-1:0]               pos;
    logic [POS_W-1:0]               pos_next;
    logic [COEF_W-1:0]              fill     [BLK_COEFS];
    logic [COEF_W-1:0]              fill_view[BLK_COEFS];
    logic [BLK_COEFS*COEF_W-1:0]    blk_pack;

    logic                           accept;
    logic [SUM_W-1:0]               target;
    logic                           wr_en;
    logic                           overflow;
    logic                           complete;
    logic                           out_free;
    logic                           transfer;

    assign in_ready = (state == FILL);

    always_comb begin
        accept   = in_valid && in_ready;
        target   = SUM_W'(pos) + SUM_W'(in_run);
        wr_en    = accept && !in_eob && (target <= LAST_IDX);
        overflow = accept && !in_eob && (target > LAST_IDX);
        complete = accept && (in_eob || overflow || (target == LAST_IDX));
        out_free = !blk_valid || blk_ready;
    end

    always_comb begin
        state_next = state;
        pos_next   = pos;
        transfer   = 1'b0;
        case (state)
            FILL: begin
                if (wr_en) begin
                    pos_next = POS_W'(target + SUM_W'(1));
                end
                if (complete) begin
                    if (out_free) begin
                        transfer = 1'b1;
                        pos_next = '0;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // blk_valid is always set here, so blk_ready alone completes the handshake.
                if (blk_ready) begin
                    transfer   = 1'b1;
                    state_next = FILL;
                    pos_next   = '0;
                end
            end
            default: begin
                state_next = FILL;
                pos_next   = '0;
            end
        endcase
    end

    // The completing write must reach the output register on the same edge.
    always_comb begin
        for (int i = 0; i < BLK_COEFS; i++) begin
            fill_view[i] = fill[i];
            if (wr_en && (target == SUM_W'(i))) begin
                fill_view[i] = in_level;
            end
        end
    end

    always_comb begin
        blk_pack = '0;
        for (int i = 0; i < BLK_COEFS; i++) begin
            blk_pack[blk_offset(i, COEF_W) +: COEF_W] = fill_view[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            pos   <= '0;
        end else begin
            state <= state_next;
            pos   <= pos_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLK_COEFS; i++) begin
                fill[i] <= '0;
            end
        end else if (transfer) begin
            for (int i = 0; i < BLK_COEFS; i++) begin
                fill[i] <= '0;
            end
        end else if (wr_en) begin
            fill[target[IDX_W-1:0]] <= in_level;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_data     <= '0;
            blk_valid    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_overflow <= overflow;
            if (transfer) begin
                blk_data  <= blk_pack;
                blk_valid <= 1'b1;
            end else if (blk_ready) begin
                blk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rle_block_assembler.sv
// Bench for rle_block_assembler: token-level block model with a per-cycle
// compare process, plus directed scenarios with literal block expectations.
module tb_rle_block_assembler;

    localparam int COEF_W = 8;
    localparam int RUN_W  = 6;
    localparam int NC     = 64;
    localparam int BW     = NC * COEF_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [RUN_W-1:0]  in_run = '0;
    logic [COEF_W-1:0] in_level = '0;
    logic              in_eob = 1'b0;
    logic [BW-1:0]     blk_data;
    logic              blk_valid;
    logic              blk_ready = 1'b0;
    logic              err_overflow;

    int errors = 0;
    int checks = 0;

    rle_block_assembler #(.COEF_W(COEF_W), .RUN_W(RUN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_run       (in_run),
        .in_level     (in_level),
        .in_eob       (in_eob),
        .blk_data     (blk_data),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .err_overflow (err_overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model + compare ----------------
    // exp_q holds completed blocks in delivery order: [0] is the output slot,
    // [1] is a block parked in the fill buffer waiting for the output.
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got_q[$];
    logic [BW-1:0] m_blk;
    int            m_pos;
    logic          m_err;
    int            err_pulses;
    int            ready_low;
    bit            e_valid, e_ready, done;
    int            t;

    initial begin
        m_blk = '0; m_pos = 0; m_err = 1'b0; err_pulses = 0; ready_low = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_blk_valid", BW'(blk_valid), BW'(0));
            check("rst_err_overflow", BW'(err_overflow), BW'(0));
            check("rst_blk_data", blk_data, '0);
            check("rst_in_ready", BW'(in_ready), BW'(1));
            exp_q.delete();
            m_blk = '0; m_pos = 0; m_err = 1'b0;
        end else begin
            e_valid = (exp_q.size() > 0);
            e_ready = (exp_q.size() < 2);
            check("in_ready", BW'(in_ready), BW'(e_ready));
            check("blk_valid", BW'(blk_valid), BW'(e_valid));
            if (e_valid) check("blk_data", blk_data, exp_q[0]);
            check("err_overflow", BW'(err_overflow), BW'(m_err));
            if (err_overflow) err_pulses++;
            if (!in_ready) ready_low++;

            m_err = 1'b0;
            done  = 1'b0;
            if (in_valid && e_ready) begin
                if (in_eob) begin
                    done = 1'b1;
                end else begin
                    t = m_pos + int'(in_run);
                    if (t > NC - 1) begin
                        m_err = 1'b1;
                        done  = 1'b1;
                    end else begin
                        m_blk[(NC - 1 - t) * COEF_W +: COEF_W] = in_level;
                        m_pos = t + 1;
                        if (m_pos == NC) done = 1'b1;
                    end
                end
            end
            if (e_valid && blk_ready) begin
                got_q.push_back(blk_data);
                void'(exp_q.pop_front());
            end
            if (done) begin
                exp_q.push_back(m_blk);
                m_blk = '0;
                m_pos = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the token is accepted.
    task automatic send(input bit eob, input int run, input int level);
        int n = 0;
        in_valid = 1'b1;
        in_eob   = eob;
        in_run   = RUN_W'(run);
        in_level = COEF_W'(level);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_eob   = 1'b0;
        in_run   = '0;
        in_level = '0;
    endtask

    task automatic wait_blocks(input int n);
        int c = 0;
        while (got_q.size() < n && c < 200) begin
            c++;
            @(negedge clk);
        end
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_blocks: got %0d blocks, required %0d", got_q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    logic [BW-1:0] exp_blk;
    int            base;
    int            err0;
    int            low0;

    initial begin
        blk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", BW'(in_ready), BW'(1));
        @(posedge clk);
        #1;

        // (0,5),(2,-3),EOB
        base = got_q.size();
        send(0, 0, 5);
        send(0, 2, -3);
        send(1, 0, 0);
        check("eob_latency_valid", BW'(blk_valid), BW'(1));
        wait_blocks(base + 1);
        exp_blk = '0;
        exp_blk[511:504] = 8'h05;
        exp_blk[487:480] = 8'hFD;
        check("t1_block", got_q[base], exp_blk);

        // 64 tokens with no EOB
        base = got_q.size();
        low0 = ready_low;
        for (int i = 0; i < NC; i++) send(0, 0, i + 1);
        check("full_latency_valid", BW'(blk_valid), BW'(1));
        check("full_ready_never_low", BW'(ready_low - low0), BW'(0));
        wait_blocks(base + 1);
        exp_blk = '0;
        for (int i = 0; i < NC; i++) exp_blk[(NC - 1 - i) * COEF_W +: COEF_W] = COEF_W'(i + 1);
        check("full_block", got_q[base], exp_blk);
        check("full_block_idx0", BW'(got_q[base][511:504]), BW'(8'h01));
        check("full_block_idx63", BW'(got_q[base][7:0]), BW'(8'h40));

        // EOB first
        base = got_q.size();
        send(1, 0, 0);
        wait_blocks(base + 1);
        check("eob_first_zero_block", got_q[base], '0);

        // overflow at pos=60
        base = got_q.size();
        err0 = err_pulses;
        send(0, 0, 1);
        send(0, 58, 2);
        send(0, 5, 7);
        check("ovf_latency_valid", BW'(blk_valid), BW'(1));
        wait_blocks(base + 1);
        check("ovf_pulse_count", BW'(err_pulses - err0), BW'(1));
        exp_blk = '0;
        exp_blk[511:504] = 8'h01;
        exp_blk[39:32]   = 8'h02;
        check("ovf_block", got_q[base], exp_blk);
        check("ovf_idx63_zero", BW'(got_q[base][7:0]), BW'(0));
        send(0, 0, 9);
        send(1, 0, 0);
        wait_blocks(base + 2);
        exp_blk = '0;
        exp_blk[511:504] = 8'h09;
        check("after_ovf_block", got_q[base + 1], exp_blk);

        // output stalled while a second block completes
        blk_ready = 1'b0;
        base = got_q.size();
        send(0, 0, 'h11);
        send(1, 0, 0);
        send(0, 1, 'h22);
        send(1, 0, 0);
        @(negedge clk);
        check("wait_in_ready_low", BW'(in_ready), BW'(0));
        check("wait_blk_valid", BW'(blk_valid), BW'(1));
        @(posedge clk);
        #1;
        fork
            send(0, 0, 'h44);
            begin
                repeat (3) @(negedge clk);
                check("wait_still_stalled", BW'(in_ready), BW'(0));
                @(posedge clk);
                #1 blk_ready = 1'b1;
            end
        join
        send(1, 0, 0);
        wait_blocks(base + 3);
        exp_blk = '0;
        exp_blk[511:504] = 8'h11;
        check("stall_block1", got_q[base], exp_blk);
        exp_blk = '0;
        exp_blk[503:496] = 8'h22;
        check("stall_block2", got_q[base + 1], exp_blk);
        exp_blk = '0;
        exp_blk[511:504] = 8'h44;
        check("stall_block3", got_q[base + 2], exp_blk);

        // reset mid-block
        base = got_q.size();
        for (int k = 0; k < 10; k++) send(0, 0, k + 1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_no_block", BW'(got_q.size()), BW'(base));
        check("reset_no_valid", BW'(blk_valid), BW'(0));
        @(posedge clk);
        #1;
        send(0, 2, 'h33);
        send(1, 0, 0);
        wait_blocks(base + 1);
        exp_blk = '0;
        exp_blk[495:488] = 8'h33;
        check("post_reset_block", got_q[base], exp_blk);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
